branch_history_table: RTL

- Dual-ported bimodal branch predictor for the 2-wide superscalar pipeline.
- Sits upstream of the memory-stage PC correction logic. It produces the per-slot predictions that travel down the pipe and arrive there as PredictionM1/PredictionM2.
- Looks up two fetch PCs each cycle.
- Accepts two resolved-branch updates per cycle from the M stage.

---
 rtl/branch_history_table_if.sv | 31 +++
 rtl/branch_history_table.sv | 97 +++++++++
 2 files changed

// File: rtl/branch_history_table_if.sv
// Bus bundle for the dual-ported bimodal branch predictor.
// The master side (pipeline control) drives fetch PCs, stall/flush and M-stage
// resolutions. The slave side (the predictor) returns the D-stage predictions.
interface branch_history_table_if #(
  parameter int unsigned PC_WIDTH = 9
);
  logic                StallF;
  logic                FlushD;
  logic [PC_WIDTH-1:0] PCF1;
  logic [PC_WIDTH-1:0] PCF2;
  logic                PredictionD1;
  logic                PredictionD2;
  logic                BranchM1;
  logic                BranchM2;
  logic [PC_WIDTH-1:0] PCM1;
  logic [PC_WIDTH-1:0] PCM2;
  logic                branch_taken1;
  logic                branch_taken2;

  modport master (
    output StallF, FlushD, PCF1, PCF2,
    output BranchM1, BranchM2, PCM1, PCM2, branch_taken1, branch_taken2,
    input  PredictionD1, PredictionD2
  );

  modport slave (
    input  StallF, FlushD, PCF1, PCF2,
    input  BranchM1, BranchM2, PCM1, PCM2, branch_taken1, branch_taken2,
    output PredictionD1, PredictionD2
  );
endinterface

// File: rtl/branch_history_table.sv
// Dual-ported bimodal branch predictor: 2^INDEX_BITS entries of 2-bit
// saturating counters, indexed by the low PC bits (no tags, aliasing allowed).
// Two lookups per cycle are registered into the D stage; two M-stage updates
// per cycle are applied in program order.
// Optional build macro: BHT_BYPASS_EN -- forward same-cycle updates to lookups.
module branch_history_table #(
  parameter int unsigned PC_WIDTH   = 9,
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input logic                  clk,
  input logic                  rst,
  branch_history_table_if.slave bus
);
  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic [1:0] table_q [DEPTH];
  logic       pred1_q, pred2_q;
  logic       pred1_d, pred2_d;

  logic [INDEX_BITS-1:0] idx_f1, idx_f2, idx_m1, idx_m2;
  logic                  same_idx;
  logic                  wr1, wr2;
  logic [1:0]            upd1, upd2;
  logic [1:0]            rd1, rd2;

  function automatic logic [1:0] sat_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign idx_f1 = bus.PCF1[INDEX_BITS-1:0];
  assign idx_f2 = bus.PCF2[INDEX_BITS-1:0];
  assign idx_m1 = bus.PCM1[INDEX_BITS-1:0];
  assign idx_m2 = bus.PCM2[INDEX_BITS-1:0];

  // Compute update values; a same-index dual update folds slot 1 into slot 2
  // so the entry receives a single combined write.
  always_comb begin
    same_idx = bus.BranchM1 && bus.BranchM2 && (idx_m1 == idx_m2);
    wr1      = bus.BranchM1 && !same_idx;
    wr2      = bus.BranchM2;
    upd1     = sat_next(table_q[idx_m1], bus.branch_taken1);
    upd2     = same_idx ? sat_next(upd1, bus.branch_taken2)
                        : sat_next(table_q[idx_m2], bus.branch_taken2);
  end

  // Lookup of both fetch slots, optionally forwarding this cycle's updates.
  always_comb begin
    rd1 = table_q[idx_f1];
    rd2 = table_q[idx_f2];
`ifdef BHT_BYPASS_EN
    if (wr1 && (idx_f1 == idx_m1)) rd1 = upd1;
    if (wr2 && (idx_f1 == idx_m2)) rd1 = upd2;
    if (wr1 && (idx_f2 == idx_m1)) rd2 = upd1;
    if (wr2 && (idx_f2 == idx_m2)) rd2 = upd2;
`else
`endif
  end

  // Counter table: reset to INIT_STATE, otherwise apply resolved branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= INIT_STATE;
    end else begin
      if (wr1) table_q[idx_m1] <= upd1;
      if (wr2) table_q[idx_m2] <= upd2;
    end
  end

  // Next prediction: flush clears, stall holds, otherwise take the lookup.
  always_comb begin
    pred1_d = pred1_q;
    pred2_d = pred2_q;
    if (bus.FlushD) begin
      pred1_d = 1'b0;
      pred2_d = 1'b0;
    end else if (!bus.StallF) begin
      pred1_d = rd1[1];
      pred2_d = rd2[1];
    end
  end

  // D-stage prediction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred1_q <= 1'b0;
      pred2_q <= 1'b0;
    end else begin
      pred1_q <= pred1_d;
      pred2_q <= pred2_d;
    end
  end

  assign bus.PredictionD1 = pred1_q;
  assign bus.PredictionD2 = pred2_q;
endmodule
